// File: rtl/cacheline_adaptor_param.sv
// Cache-line to pmem burst bridge: one LINE_W request becomes LINE_W/BURST_W pmem beats.
// Optional macro ADAPTOR_WRAP_EN selects critical-word-first beat order instead of linear.
module cacheline_adaptor_param #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic               read_o,
    output logic               write_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CW    = $clog2(BEATS);
`ifdef ADAPTOR_WRAP_EN
    // Beat-aligned address: the bits just above the beat offset carry the start beat.
    localparam int ALO = $clog2(BURST_W / 8);
`else
    localparam int ALO = $clog2(LINE_W / 8);
`endif

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         beat_q, beat_d;
    logic [ADDR_W-1:ALO]   addr_q, addr_d;
    logic [LINE_W-1:0]     buf_q, buf_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [CW-1:0]         slot;
    logic                  last_beat;
    logic                  unused_addr_lo;

    assign unused_addr_lo = ^address_i[ALO-1:0];

`ifdef ADAPTOR_WRAP_EN
    assign slot = beat_q + addr_q[ALO+CW-1:ALO];
`else
    assign slot = beat_q;
`endif
    assign last_beat = (beat_q == CW'(BEATS - 1));
    assign line_o    = line_q;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        line_d    = line_q;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = address_i[ADDR_W-1:ALO];
                    buf_d   = line_i;
                    beat_d  = '0;
                    state_d = WR;
                end else if (read_i) begin
                    addr_d  = address_i[ADDR_W-1:ALO];
                    beat_d  = '0;
                    state_d = RD;
                end
            end
            RD: begin
                read_o    = 1'b1;
                address_o = {addr_q, {ALO{1'b0}}};
                if (resp_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (slot == CW'(b)) buf_d[b*BURST_W +: BURST_W] = burst_i;
                    end
                    beat_d = beat_q + 1'b1;
                    // line_o only changes once a whole line has arrived
                    if (last_beat) begin
                        line_d  = buf_d;
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                write_o   = 1'b1;
                address_o = {addr_q, {ALO{1'b0}}};
                for (int b = 0; b < BEATS; b++) begin
                    if (slot == CW'(b)) burst_o = buf_q[b*BURST_W +: BURST_W];
                end
                if (resp_i) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = DONE;
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
        end
    end
endmodule
